// File: rtl/timer_dev_if.sv
// rtl/timer_dev_if.sv - word-addressed register bus between the system bridge and timer_dev
interface timer_dev_if;
  logic [29:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (
    output addr,
    output we,
    output wdata,
    input  rdata,
    input  irq
  );

  modport slave (
    input  addr,
    input  we,
    input  wdata,
    output rdata,
    output irq
  );
endinterface

// File: rtl/timer_dev.sv
// rtl/timer_dev.sv - memory-mapped down-counting timer with one-shot and auto-reload modes
// Registers: CTRL (EN, MODE, IM), PRESET, COUNT (read-only); irq = IM & irq_flag.
module timer_dev #(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  timer_dev_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;
  localparam logic [1:0] MODE_RELOAD = 2'd1;

  state_t             state_q, state_d;
  logic               en_q, en_d;
  logic [1:0]         mode_q, mode_d;
  logic               im_q, im_d;
  logic [CNT_W-1:0]   preset_q, preset_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               irq_flag_q, irq_flag_d;

  logic               wr_ctrl;
  logic               wr_preset;
  logic               flag_set;
  logic               flag_drop;
  logic               en_drop;
  logic [31:0]        rdata_c;
  logic               unused_bits;

  assign wr_ctrl   = bus.we && (bus.addr[1:0] == OFF_CTRL);
  assign wr_preset = bus.we && (bus.addr[1:0] == OFF_PRESET);

  // Only the word offset is decoded; the bridge already matched the base.
  assign unused_bits = ^{bus.addr[29:2], bus.wdata};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      en_q       <= 1'b0;
      mode_q     <= 2'd0;
      im_q       <= 1'b0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      mode_q     <= mode_d;
      im_q       <= im_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    en_d       = en_q;
    mode_d     = mode_q;
    im_d       = im_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;
    flag_set   = 1'b0;
    flag_drop  = 1'b0;
    en_drop    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (en_q) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        // The count stops at zero; expiry is taken from 1 (or a zero preset).
        if (!en_q) begin
          state_d = ST_IDLE;
        end else if (count_q > CNT_W'(1)) begin
          count_d = count_q - CNT_W'(1);
        end else begin
          count_d  = '0;
          flag_set = 1'b1;
          state_d  = ST_INT;
        end
      end
      ST_INT: begin
        // Reserved modes 2/3 fall into the one-shot branch.
        if (mode_q == MODE_RELOAD) begin
          flag_drop = 1'b1;
          state_d   = ST_LOAD;
        end else begin
          en_drop = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (en_drop) begin
      en_d = 1'b0;
    end

    // A CPU write to CTRL lands after the FSM so its value wins.
    if (wr_ctrl) begin
      en_d   = bus.wdata[0];
      mode_d = bus.wdata[2:1];
      im_d   = bus.wdata[3];
    end

    if (wr_preset) begin
      preset_d = bus.wdata[CNT_W-1:0];
    end

    if (flag_drop || wr_ctrl || wr_preset) begin
      irq_flag_d = 1'b0;
    end
    if (flag_set) begin
      irq_flag_d = 1'b1;
    end
  end

  always_comb begin
    rdata_c = '0;
    case (bus.addr[1:0])
      OFF_CTRL:   rdata_c[3:0]       = {im_q, mode_q, en_q};
      OFF_PRESET: rdata_c[CNT_W-1:0] = preset_q;
      OFF_COUNT:  rdata_c[CNT_W-1:0] = count_q;
      default:    rdata_c            = '0;
    endcase
  end

  assign bus.rdata = rdata_c;
  assign bus.irq   = im_q & irq_flag_q;

endmodule
